// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FWD_W      = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  use_rs;
        logic                  use_rt;
        logic [REG_ADDR_W-1:0] dst;
        logic                  regwrite;
        logic                  is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // True when the slot will write register r (r0 never counts)
    function automatic logic slot_writes(input slot_t s, input logic [REG_ADDR_W-1:0] r);
        return s.valid && s.regwrite && (s.dst == r) && (r != '0);
    endfunction

    // Operand source for a used register: MEM result beats WB data
    function automatic logic [FWD_W-1:0] fwd_pick(input slot_t mem, input slot_t wb,
                                                  input logic used,
                                                  input logic [REG_ADDR_W-1:0] r);
        logic [FWD_W-1:0] sel;
        sel = FWD_RF;
        if (used) begin
            if (slot_writes(mem, r)) begin
                sel = FWD_MEM;
            end else if (slot_writes(wb, r)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module hazard_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: scoreboard of EX/MEM/WB destinations,
// RAW hazard stalls, branch-redirect flush, operand forwarding selects and
// saturating stall/flush counters.
// Build option: PIPE_HAZARD_FORWARDING_EN enables forwarding (load-use stalls
// only); without it every RAW against EX/MEM/WB stalls and selects stay 00.
import pipe_pkg::*;

module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_regwrite,
    input  logic                  id_is_load,
    input  logic                  ex_redirect,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    slot_t  ex_q;
    slot_t  mem_q;
    slot_t  wb_q;
    slot_t  id_slot;
    state_t state;
    logic   raw_rs;
    logic   raw_rt;
    logic   hazard;
    logic   issue;
    logic   stall_cyc;
    logic   flush_cyc;

    assign id_slot = '{valid:    id_valid,
                       rs:       id_rs,
                       rt:       id_rt,
                       use_rs:   id_use_rs,
                       use_rt:   id_use_rt,
                       dst:      id_dst,
                       regwrite: id_regwrite,
                       is_load:  id_is_load};

`ifdef PIPE_HAZARD_FORWARDING_EN
    // Only a load still in EX cannot be forwarded in time
    assign raw_rs = id_use_rs && ex_q.is_load && slot_writes(ex_q, id_rs);
    assign raw_rt = id_use_rt && ex_q.is_load && slot_writes(ex_q, id_rt);
`else
    // Without forwarding, any pending writer blocks the reader
    assign raw_rs = id_use_rs && (slot_writes(ex_q, id_rs) || slot_writes(mem_q, id_rs) ||
                                  slot_writes(wb_q, id_rs));
    assign raw_rt = id_use_rt && (slot_writes(ex_q, id_rt) || slot_writes(mem_q, id_rt) ||
                                  slot_writes(wb_q, id_rt));
`endif

    assign hazard    = id_valid && (raw_rs || raw_rt);
    assign issue     = id_valid && !hazard && !ex_redirect && !rst;
    assign stall_cyc = !rst && !ex_redirect && hazard;
    assign flush_cyc = !rst && ex_redirect;

    // Advance the scoreboard; a non-issuing cycle enters EX as a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= issue ? id_slot : SLOT_EMPTY;
        end
    end

    // Debug-visible stall state; outputs do not depend on it
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (hazard && !ex_redirect) state <= ST_STALL;
                ST_STALL: if (!hazard || ex_redirect) state <= ST_RUN;
            endcase
        end
    end

    // Pipeline enables: reset, then redirect, then hazard, then normal flow
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = !id_valid;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

`ifdef PIPE_HAZARD_FORWARDING_EN
    // Operand sources for the instruction currently in EX
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!rst && ex_q.valid) begin
            fwd_a = fwd_pick(mem_q, wb_q, ex_q.use_rs, ex_q.rs);
            fwd_b = fwd_pick(mem_q, wb_q, ex_q.use_rt, ex_q.rt);
        end
    end
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_cyc),
        .count (stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_cyc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl (both PIPE_HAZARD_FORWARDING_EN builds).
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int unsigned CNT_W = 16;
`ifdef PIPE_HAZARD_FORWARDING_EN
    localparam int S = 1;
`else
    localparam int S = 3;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_use_rs;
    logic                  id_use_rt;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_regwrite;
    logic                  id_is_load;
    logic                  ex_redirect;
    logic                  pc_we;
    logic                  ifid_we;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       rw;
        logic       ld;
        logic       redir;
        logic [3:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        int         stall;
        int         flush;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_dst      (id_dst),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .ex_redirect (ex_redirect),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    function automatic void av(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] dst,
                               input logic rw, input logic ld, input logic redir,
                               input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                               input int stall, input int flush);
        vec_t v;
        v.valid = valid; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.dst = dst;
        v.rw = rw; v.ld = ld; v.redir = redir; v.ctl = ctl; v.fa = fa; v.fb = fb;
        v.stall = stall; v.flush = flush;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic rw, input logic ld, input logic redir);
        id_valid = valid; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_dst = dst; id_regwrite = rw; id_is_load = ld; ex_redirect = redir;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] ctl_now();
        return {pc_we, ifid_we, ifid_flush, idex_bubble};
    endfunction

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

`ifdef PIPE_HAZARD_FORWARDING_EN
        // lw r8 then add reading r8: one load-use stall, then WB forward
        av(1, 1, 0, 1, 0, 8, 1, 1, 0, 4'b1100, 2'b00, 2'b00, 0, 0);
        av(1, 8, 2, 1, 1, 9, 1, 0, 0, 4'b0001, 2'b00, 2'b00, 0, 0);
        av(1, 8, 2, 1, 1, 9, 1, 0, 0, 4'b1100, 2'b00, 2'b00, 1, 0);
        // add r3 then add r5=r3+r4: no stall, MEM forward
        av(1, 1, 2, 1, 1, 3, 1, 0, 0, 4'b1100, 2'b10, 2'b00, 1, 0);
        av(1, 3, 4, 1, 1, 5, 1, 0, 0, 4'b1100, 2'b00, 2'b00, 1, 0);
        av(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101, 2'b01, 2'b00, 1, 0);
`else
        // add r3 then add r5=r3+r4: stalls while r3 sits in EX, MEM, WB
        av(1, 1, 2, 1, 1, 3, 1, 0, 0, 4'b1100, 2'b00, 2'b00, 0, 0);
        av(1, 3, 4, 1, 1, 5, 1, 0, 0, 4'b0001, 2'b00, 2'b00, 0, 0);
        av(1, 3, 4, 1, 1, 5, 1, 0, 0, 4'b0001, 2'b00, 2'b00, 1, 0);
        av(1, 3, 4, 1, 1, 5, 1, 0, 0, 4'b0001, 2'b00, 2'b00, 2, 0);
        av(1, 3, 4, 1, 1, 5, 1, 0, 0, 4'b1100, 2'b00, 2'b00, 3, 0);
`endif
        // r0 writer then r0 reader: never a hazard, never forwarded
        av(1, 1, 2, 1, 1, 0, 1, 0, 0, 4'b1100, 2'b00, 2'b00, S, 0);
        av(1, 0, 0, 1, 1, 6, 1, 0, 0, 4'b1100, 2'b00, 2'b00, S, 0);
        // load-use coinciding with redirect: flush wins, no stall counted
        av(1, 1, 0, 1, 0, 8, 1, 1, 0, 4'b1100, 2'b00, 2'b00, S, 0);
        av(1, 8, 2, 1, 1, 9, 1, 0, 1, 4'b1111, 2'b00, 2'b00, S, 0);
        av(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101, 2'b00, 2'b00, S, 1);

        // reset state
        @(posedge clk);
        @(negedge clk);
        #1;
        check("reset ctl", 32'(ctl_now()), 32'h3);
        check("reset fwd", 32'({fwd_a, fwd_b}), 32'h0);
        check("reset stall_cnt", 32'(stall_cnt), 32'h0);
        check("reset flush_cnt", 32'(flush_cnt), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
                  vecs[i].dst, vecs[i].rw, vecs[i].ld, vecs[i].redir);
            #1;
            check($sformatf("row%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            check($sformatf("row%0d fwd_a", i), 32'(fwd_a), 32'(vecs[i].fa));
            check($sformatf("row%0d fwd_b", i), 32'(fwd_b), 32'(vecs[i].fb));
            check($sformatf("row%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].stall));
            check($sformatf("row%0d flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].flush));
            @(negedge clk);
        end

        // reset asserted in the middle of a load-use stall
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        #1;
        check("mid lw issue", 32'(ctl_now()), 32'hC);
        @(negedge clk);
        drive(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        check("mid stall ctl", 32'(ctl_now()), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid rst ctl", 32'(ctl_now()), 32'h3);
        check("mid rst fwd", 32'({fwd_a, fwd_b}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post rst issue ctl", 32'(ctl_now()), 32'hC);
        check("post rst stall_cnt", 32'(stall_cnt), 32'h0);
        check("post rst flush_cnt", 32'(flush_cnt), 32'h0);

        // flush counter saturation over 2^16+5 redirects
        for (int i = 0; i < 65541; i++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            if (i == 65534) begin
                #1;
                check("flush_cnt below top", 32'(flush_cnt), 32'hFFFE);
            end
        end
        @(negedge clk);
        ex_redirect = 1'b0;
        #1;
        check("flush_cnt saturated", 32'(flush_cnt), 32'hFFFF);
        check("stall_cnt after redirects", 32'(stall_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
